fetch_queue_ctrl: RTL and testbench

- Consumer and controller on the program-counter interface.
- Drives pc_next / pc_write into the PC register and samples pc_current together with the instruction word returned by instruction memory.
- Buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Handles back-pressure (PC stall when full) and branch redirects (flush plus PC load).

---
 rtl/fetch_queue_ctrl_if.sv | 29 ++
 rtl/fetch_queue_ctrl.sv | 81 ++++++++
 tb/tb_fetch_queue_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch-side bundle: PC register / imem view plus the decode valid/ready channel.
interface fetch_queue_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_current;
  logic [31:0]   instr_in;
  logic          imem_stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   pc_next;
  logic          pc_write;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   deq_pc;
  logic [31:0]   deq_instr;
  logic [CW-1:0] queue_count;

  modport slave (
    input  pc_current, instr_in, imem_stall, redirect_valid, redirect_pc, deq_ready,
    output pc_next, pc_write, deq_valid, deq_pc, deq_instr, queue_count
  );

  modport master (
    output pc_current, instr_in, imem_stall, redirect_valid, redirect_pc, deq_ready,
    input  pc_next, pc_write, deq_valid, deq_pc, deq_instr, queue_count
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Fetch queue controller: steps the PC, buffers {pc, instr} pairs in a circular
// FIFO for decode, stalls the PC when full and flushes on redirect.
module fetch_queue_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_queue_ctrl_if.slave fq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic full;
  logic enq_fire;
  logic deq_fire;

  // Full blocks enqueue even when decode drains this cycle: keeps deq_ready off the PC path.
  assign full     = (count_q == CW'(DEPTH));
  assign enq_fire = reset & ~fq.redirect_valid & ~fq.imem_stall & ~full;
  assign deq_fire = fq.deq_valid & fq.deq_ready;

  assign fq.deq_valid   = reset & (count_q != '0) & ~fq.redirect_valid;
  assign fq.deq_pc      = pc_mem_q[rd_ptr_q];
  assign fq.deq_instr   = instr_mem_q[rd_ptr_q];
  assign fq.queue_count = reset ? count_q : '0;

  always_comb begin
    fq.pc_write = 1'b0;
    fq.pc_next  = fq.pc_current;
    if (!reset) begin
      fq.pc_next = RESET_PC;
    end else if (fq.redirect_valid) begin
      fq.pc_write = 1'b1;
      fq.pc_next  = {fq.redirect_pc[31:2], 2'b00};
    end else if (enq_fire) begin
      fq.pc_write = 1'b1;
      fq.pc_next  = fq.pc_current + 32'd4;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fq.redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem_q[wr_ptr_q]    <= fq.pc_current;
      instr_mem_q[wr_ptr_q] <= fq.instr_in;
    end
  end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Self-checking bench for fetch_queue_ctrl: PC/FIFO model with a {pc, instr} scoreboard.
module tb_fetch_queue_ctrl;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_ctrl_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .fq   (fq)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc = RESET_PC;
  int          m_cnt = 0;
  logic [63:0] sb[$];
  logic        e_enq = 1'b0, e_write = 1'b0, e_dvalid = 1'b0;
  logic [31:0] e_next = RESET_PC;

  // Apply one cycle of inputs; the PC register is modelled by the bench.
  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic stall, input logic rdy);
    reset             = rst;
    fq.redirect_valid = redir;
    fq.redirect_pc    = rpc;
    fq.imem_stall     = stall;
    fq.deq_ready      = rdy;
    fq.pc_current     = m_pc;
    fq.instr_in       = m_pc ^ XMASK;
    e_enq    = rst && !redir && !stall && (m_cnt < DEPTH);
    e_dvalid = rst && (m_cnt != 0) && !redir;
    if (!rst)        begin e_write = 1'b0; e_next = RESET_PC; end
    else if (redir)  begin e_write = 1'b1; e_next = {rpc[31:2], 2'b00}; end
    else if (e_enq)  begin e_write = 1'b1; e_next = m_pc + 32'd4; end
    else             begin e_write = 1'b0; e_next = m_pc; end
    if (e_enq) sb.push_back({m_pc, m_pc ^ XMASK});
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset || fq.redirect_valid) begin
      m_cnt = 0;
      sb.delete();
    end else begin
      m_cnt = m_cnt + int'(e_enq) - int'(e_dvalid && fq.deq_ready);
    end
    if (!reset) m_pc = RESET_PC;
    else if (e_write) m_pc = e_next;
    #1;
  endtask

  always @(negedge clk) begin
    logic [63:0] exp_e;
    tests++;
    if (fq.deq_valid !== e_dvalid) begin
      fails++;
      $display("FAIL mon_deq_valid: got %b want %b", fq.deq_valid, e_dvalid);
    end
    if (e_dvalid && fq.deq_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL mon_sb_empty: got deq_pc %h want no entry", fq.deq_pc);
      end else begin
        exp_e = sb.pop_front();
        if ({fq.deq_pc, fq.deq_instr} !== exp_e) begin
          fails++;
          $display("FAIL mon_deq_entry: got %h/%h want %h/%h", fq.deq_pc, fq.deq_instr,
                   exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tests++; if (fq.pc_write !== 1'b0) begin fails++; $display("FAIL reset_pc_write: got %b want 0", fq.pc_write); end
      tests++; if (fq.pc_next !== RESET_PC) begin fails++; $display("FAIL reset_pc_next: got %h want %h", fq.pc_next, RESET_PC); end
      tests++; if (fq.deq_valid !== 1'b0) begin fails++; $display("FAIL reset_deq_valid: got %b want 0", fq.deq_valid); end
      tests++; if (fq.queue_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fq.queue_count); end
      tick();
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      tests++; if (fq.pc_write !== 1'b1) begin fails++; $display("FAIL stream_pc_write: got %b want 1", fq.pc_write); end
      tests++; if (fq.pc_next !== 32'(4 * (i + 1))) begin fails++; $display("FAIL stream_pc_next: got %h want %h", fq.pc_next, 32'(4 * (i + 1))); end
      if (i >= 1) begin
        tests++; if (fq.deq_pc !== 32'(4 * (i - 1))) begin fails++; $display("FAIL stream_deq_pc: got %h want %h", fq.deq_pc, 32'(4 * (i - 1))); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      if (i >= 4) begin
        tests++; if (fq.queue_count !== 3'd4) begin fails++; $display("FAIL bp_count: got %0d want 4", fq.queue_count); end
        tests++; if (fq.pc_write !== 1'b0) begin fails++; $display("FAIL bp_pc_write: got %b want 0", fq.pc_write); end
        tests++; if (fq.pc_next !== 32'h10) begin fails++; $display("FAIL bp_pc_next: got %h want 00000010", fq.pc_next); end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      tests++; if (fq.deq_pc !== 32'(4 * i)) begin fails++; $display("FAIL bp_drain_pc: got %h want %h", fq.deq_pc, 32'(4 * i)); end
      if (i == 0) begin
        tests++; if (fq.pc_write !== 1'b0) begin fails++; $display("FAIL bp_full_deq_write: got %b want 0", fq.pc_write); end
      end
      if (i == 1) begin
        tests++; if (fq.pc_next !== 32'h14) begin fails++; $display("FAIL bp_resume_next: got %h want 00000014", fq.pc_next); end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick(); end
    drive(1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
    tests++; if (fq.pc_next !== 32'h100) begin fails++; $display("FAIL redir_pc_next: got %h want 00000100", fq.pc_next); end
    tests++; if (fq.pc_write !== 1'b1) begin fails++; $display("FAIL redir_pc_write: got %b want 1", fq.pc_write); end
    tests++; if (fq.deq_valid !== 1'b0) begin fails++; $display("FAIL redir_deq_valid: got %b want 0", fq.deq_valid); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.queue_count !== 3'd0) begin fails++; $display("FAIL redir_count: got %0d want 0", fq.queue_count); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.deq_pc !== 32'h100) begin fails++; $display("FAIL redir_deq_pc: got %h want 00000100", fq.deq_pc); end
    tick();
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
    tests++; if (fq.pc_next !== 32'h300) begin fails++; $display("FAIL b2b_pc_next: got %h want 00000300", fq.pc_next); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tests++; if (fq.queue_count !== 3'd0) begin fails++; $display("FAIL b2b_count: got %0d want 0", fq.queue_count); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tests++; if (fq.deq_pc !== 32'h300) begin fails++; $display("FAIL b2b_deq_pc: got %h want 00000300", fq.deq_pc); end
    tick();
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h18, 1'b0, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick(); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      tests++; if (fq.pc_write !== 1'b0) begin fails++; $display("FAIL stall_pc_write: got %b want 0", fq.pc_write); end
      tests++; if (fq.pc_next !== 32'h20) begin fails++; $display("FAIL stall_pc_next: got %h want 00000020", fq.pc_next); end
      tests++; if (fq.queue_count !== 3'(2 - i)) begin fails++; $display("FAIL stall_count: got %0d want %0d", fq.queue_count, 2 - i); end
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.pc_next !== 32'h24) begin fails++; $display("FAIL stall_release_next: got %h want 00000024", fq.pc_next); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.deq_pc !== 32'h20) begin fails++; $display("FAIL stall_deq_20: got %h want 00000020", fq.deq_pc); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.deq_pc !== 32'h24) begin fails++; $display("FAIL stall_deq_24: got %h want 00000024", fq.deq_pc); end
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tests++; if (fq.pc_next !== 32'h0) begin fails++; $display("FAIL wrap_pc_next: got %h want 00000000", fq.pc_next); end
    tests++; if (fq.pc_write !== 1'b1) begin fails++; $display("FAIL wrap_pc_write: got %b want 1", fq.pc_write); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.deq_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_deq_pc: got %h want fffffffc", fq.deq_pc); end
    tests++; if (fq.deq_instr !== 32'h5A5A_FFFC) begin fails++; $display("FAIL wrap_deq_instr: got %h want 5a5afffc", fq.deq_instr); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick(); end
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
    tests++; if (fq.pc_write !== 1'b0) begin fails++; $display("FAIL rmid_pc_write: got %b want 0", fq.pc_write); end
    tests++; if (fq.pc_next !== RESET_PC) begin fails++; $display("FAIL rmid_pc_next: got %h want %h", fq.pc_next, RESET_PC); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.queue_count !== 3'd0) begin fails++; $display("FAIL rmid_count: got %0d want 0", fq.queue_count); end
    tests++; if (fq.deq_valid !== 1'b0) begin fails++; $display("FAIL rmid_deq_valid: got %b want 0", fq.deq_valid); end
    tests++; if (fq.pc_next !== 32'h4) begin fails++; $display("FAIL rmid_restart_next: got %h want 00000004", fq.pc_next); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tests++; if (fq.deq_pc !== 32'h0) begin fails++; $display("FAIL rmid_deq_pc: got %h want 00000000", fq.deq_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_stall();
    test_wrap();
    test_reset_mid();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
